// File: rtl/addsub_pipe_ctrl.sv
// Two-stage add/subtract pipeline with valid/ready handshakes on both sides.
// S1 registers operands and feeds a ripple adder; S2 registers result and flags.

module addsub_full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);
    always_comb begin
        sum   = a ^ b ^ c_in;
        c_out = (a & b) | (c_in & (a ^ b));
    end
endmodule

module addsub_ripple_array #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);
    logic [WIDTH:0] carry;

    assign carry[0] = c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        addsub_full_adder u_fa (
            .a     (a[i]),
            .b     (b[i]),
            .c_in  (carry[i]),
            .sum   (sum[i]),
            .c_out (carry[i+1])
        );
    end

    assign c_out = carry[WIDTH];
endmodule

module addsub_pipe_ctrl #(
    parameter int unsigned ADDER_WIDTH = 32,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDER_WIDTH-1:0] in_a,
    input  logic [ADDER_WIDTH-1:0] in_b,
    input  logic                   in_sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDER_WIDTH-1:0] out_result,
    output logic                   out_carry,
    output logic                   out_overflow,
    output logic                   out_zero,
    output logic [CNT_WIDTH-1:0]   op_count
);
    logic                   s1_valid;
    logic [ADDER_WIDTH-1:0] s1_a;
    logic [ADDER_WIDTH-1:0] s1_b;
    logic                   s1_sub;

    logic                   s2_free;
    logic                   accept;
    logic                   advance;
    logic                   take;

    logic [ADDER_WIDTH-1:0] b_eff;
    logic [ADDER_WIDTH-1:0] sum;
    logic                   carry;
    logic                   overflow;

    assign s2_free  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_free;
    assign accept   = in_valid && in_ready;
    assign advance  = s1_valid && s2_free;
    assign take     = out_valid && out_ready;

    // Subtraction is A + ~B + 1, so the carry-out reads as "no borrow".
    assign b_eff = s1_b ^ {ADDER_WIDTH{s1_sub}};

    addsub_ripple_array #(
        .WIDTH (ADDER_WIDTH)
    ) u_adder (
        .a     (s1_a),
        .b     (b_eff),
        .c_in  (s1_sub),
        .sum   (sum),
        .c_out (carry)
    );

    assign overflow = (s1_a[ADDER_WIDTH-1] == b_eff[ADDER_WIDTH-1])
                   && (sum[ADDER_WIDTH-1] != s1_a[ADDER_WIDTH-1]);

    // Accept has priority: in_ready guarantees a full S1 is also advancing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_sub   <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_a     <= in_a;
            s1_b     <= in_b;
            s1_sub   <= in_sub;
        end else if (advance) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_carry    <= 1'b0;
            out_overflow <= 1'b0;
            out_zero     <= 1'b0;
        end else if (advance) begin
            out_valid    <= 1'b1;
            out_result   <= sum;
            out_carry    <= carry;
            out_overflow <= overflow;
            out_zero     <= (sum == '0);
        end else if (take) begin
            out_valid    <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= '0;
        end else if (take && (op_count != '1)) begin
            op_count <= op_count + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_addsub_pipe_ctrl.sv
// Randomized and directed bench for addsub_pipe_ctrl (8-bit) against a queue-based reference.
// A second instance with a 4-bit counter shares the stimulus to exercise saturation.

module tb_addsub_pipe_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_carry;
    logic         out_overflow;
    logic         out_zero;
    logic [15:0]  op_count;

    logic         sat_in_ready;
    logic         sat_out_valid;
    logic [W-1:0] sat_out_result;
    logic         sat_out_carry;
    logic         sat_out_overflow;
    logic         sat_out_zero;
    logic [3:0]   sat_op_count;

    always #5 clk = ~clk;

    addsub_pipe_ctrl #(.ADDER_WIDTH(W), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_carry(out_carry),
        .out_overflow(out_overflow), .out_zero(out_zero), .op_count(op_count)
    );

    addsub_pipe_ctrl #(.ADDER_WIDTH(W), .CNT_WIDTH(4)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .out_valid(sat_out_valid),
        .out_ready(out_ready), .out_result(sat_out_result), .out_carry(sat_out_carry),
        .out_overflow(sat_out_overflow), .out_zero(sat_out_zero), .op_count(sat_op_count)
    );

    typedef struct {
        logic [W-1:0] result;
        logic         carry;
        logic         ovf;
        logic         zero;
        int           step;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   xfers = 0;
    int   step_no = 0;
    bit   prev_stall = 1'b0;
    bit   acc;
    bit   got_in;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference arithmetic on plain integers, independent of any adder structure.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        exp_t e;
        int ua = a;
        int ub = b;
        int sa = $signed(a);
        int sb = $signed(b);
        int r;
        if (sub) begin
            r        = sa - sb;
            e.result = W'(ua - ub);
            e.carry  = (ua >= ub);
        end else begin
            r        = sa + sb;
            e.result = W'(ua + ub);
            e.carry  = ((ua + ub) > 255);
        end
        e.ovf  = (r > 127) || (r < -128);
        e.zero = (e.result == 0);
        e.step = step_no;
        return e;
    endfunction

    function automatic int sat15(input int n);
        return (n > 15) ? 15 : n;
    endfunction

    // One clock cycle: drive, sample at negedge, update the model, resume at posedge+1.
    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic ordy, input int exp_rdy,
                        input bit stream, output bit accepted);
        exp_t e;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_sub    = sub;
        out_ready = ordy;
        @(negedge clk);
        if (prev_stall) check_eq("valid_hold", out_valid, 1);
        if (out_valid) begin
            if (q.size() == 0) begin
                check_eq("spurious_out", out_valid, 0);
            end else begin
                e = q[0];
                check_eq("result", out_result, e.result);
                check_eq("carry", out_carry, e.carry);
                check_eq("overflow", out_overflow, e.ovf);
                check_eq("zero", out_zero, e.zero);
                check_eq("latency_min", (step_no - e.step) >= 2, 1);
            end
        end else if (stream && q.size() != 0 && (step_no - q[0].step) >= 2) begin
            check_eq("stream_valid", out_valid, 1);
        end
        check_eq("op_count", op_count, xfers);
        check_eq("op_count_sat", sat_op_count, sat15(xfers));
        if (ordy) check_eq("in_ready_thru", in_ready, 1);
        if (exp_rdy >= 0) check_eq("in_ready_bp", in_ready, exp_rdy[0]);
        accepted = v && in_ready;
        if (out_valid && ordy && q.size() != 0) begin
            void'(q.pop_front());
            xfers++;
        end
        if (accepted) q.push_back(model(a, b, sub));
        prev_stall = out_valid && !ordy;
        step_no++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic ordy);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, W'($urandom), W'($urandom), 1'($urandom), ordy, -1, 1'b1, a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;
        #3;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_result", out_result, 0);
        check_eq("rst_flags", {out_carry, out_overflow, out_zero}, 0);
        check_eq("rst_op_count", op_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed arithmetic corners.
        step(1'b1, 8'h7F, 8'h01, 1'b0, 1'b1, -1, 1'b1, acc);
        step(1'b1, 8'h05, 8'h05, 1'b1, 1'b1, -1, 1'b1, acc);
        step(1'b1, 8'h00, 8'h01, 1'b1, 1'b1, -1, 1'b1, acc);
        step(1'b1, 8'h00, 8'h80, 1'b1, 1'b1, -1, 1'b1, acc);
        step(1'b1, 8'hFF, 8'h01, 1'b0, 1'b1, -1, 1'b1, acc);
        idle(3, 1'b1);

        // Backpressure: two accepts, then stall on the third.
        step(1'b1, 8'h11, 8'h22, 1'b0, 1'b0, 1, 1'b0, acc);
        step(1'b1, 8'h33, 8'h44, 1'b0, 1'b0, 1, 1'b0, acc);
        step(1'b1, 8'h55, 8'h66, 1'b1, 1'b0, 0, 1'b0, acc);
        step(1'b1, 8'h55, 8'h66, 1'b1, 1'b0, 0, 1'b0, acc);
        step(1'b1, 8'h55, 8'h66, 1'b1, 1'b0, 0, 1'b0, acc);
        got_in = 1'b0;
        for (int i = 0; i < 10 && !got_in; i++) begin
            step(1'b1, 8'h55, 8'h66, 1'b1, 1'b1, -1, 1'b0, acc);
            got_in = acc;
        end
        check_eq("bp_third_accepted", got_in, 1);
        idle(4, 1'b1);
        check_eq("bp_drained", q.size(), 0);

        // Reset with both stages full.
        step(1'b1, 8'hA1, 8'h0F, 1'b0, 1'b0, -1, 1'b0, acc);
        step(1'b1, 8'hB2, 8'h1E, 1'b1, 1'b0, -1, 1'b0, acc);
        rst = 1'b1;
        #1;
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_in_ready", in_ready, 1);
        check_eq("midrst_result", out_result, 0);
        check_eq("midrst_op_count", op_count, 0);
        check_eq("midrst_sat_count", sat_op_count, 0);
        in_valid = 1'b1; in_a = 8'hC3; in_b = 8'h3C; out_ready = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_edge_no_accept", in_ready, 1);
        check_eq("rst_edge_out_valid", out_valid, 0);
        rst = 1'b0;
        q.delete();
        xfers = 0;
        prev_stall = 1'b0;
        idle(4, 1'b1);

        // Full-throughput stream.
        for (int i = 0; i < 100; i++) begin
            step(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b1, -1, 1'b1, acc);
            check_eq("stream_accept", acc, 1);
        end
        idle(3, 1'b1);
        check_eq("stream_op_count", op_count, 100);
        check_eq("stream_sat_count", sat_op_count, 15);

        // Random handshakes on both sides; bus noise while in_valid is low.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom), W'($urandom), W'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) != 0), -1, 1'b0, acc);
        end
        idle(6, 1'b1);
        check_eq("final_drained", q.size(), 0);
        check_eq("final_out_valid", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
